// File: rtl/uart_rx_fifo_bridge_pkg.sv
// uart_pkg: shared definitions for the UART RX FIFO bridge.
//   - UART Lite register offsets (RX, TX, STAT, CTRL)
//   - AXI response code for OKAY
//   - bridge FSM state encoding
package uart_pkg;

    localparam logic [3:0] UART_RX   = 4'h0;
    localparam logic [3:0] UART_TX   = 4'h4;
    localparam logic [3:0] UART_STAT = 4'h8;
    localparam logic [3:0] UART_CTRL = 4'hC;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        FWD_AR,
        FWD_R,
        MMU_RESP,
        POLL_STAT_AR,
        POLL_STAT_R,
        POLL_RX_AR,
        POLL_RX_R
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_bridge_if.sv
// uart_rx_fifo_bridge_if: AXI4-Lite bundle (4-bit address, 32-bit data).
//   master modport: drives AR/AW/W and rready/bready (the requester side)
//   slave  modport: drives arready/R/awready/wready/B (the responder side)
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high; once valid is raised, it and its
// payload stay stable until that transfer; ready may depend on valid.
interface uart_rx_fifo_bridge_if;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/uart_rx_fifo_bridge_byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with wrap-bit pointers.
//   clk, rstn        clock, synchronous active-low reset (empties the FIFO)
//   push_i, wdata_i  write one byte (ignored when full)
//   pop_i            drop the head byte (ignored when empty)
//   rdata_o          head byte (valid when !empty_o)
//   full_o, empty_o  status
//   level_o          occupancy, 0..DEPTH
module byte_fifo #(
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] head_q, head_d;
    logic [AW:0] tail_q, tail_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (head_q == tail_q);
    assign full_o  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign level_o = tail_q - head_q;
    assign rdata_o = mem_q[head_q[AW-1:0]];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (push_i && !full_o) tail_d = tail_q + (AW+1)'(1);
        if (pop_i && !empty_o) head_d = head_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[tail_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/uart_rx_fifo_bridge.sv
// uart_rx_fifo_bridge: AXI4-Lite read-path bridge between the MMU and the
// UART Lite core. Background polling drains UART RX bytes into a local FIFO;
// MMU reads of RX are served from the FIFO when it holds data and forwarded
// to the UART otherwise. Write channels are a combinational pass-through.
//   clk, rstn    clock, synchronous active-low reset
//   mmu_axi      slave port toward the MMU
//   uart_axi     master port toward the UART
//   dbg_state_o  current FSM state
//   rx_level_o, rx_hwm_o  occupancy and sticky peak occupancy; present only
//                when UART_RXBUF_STATS_EN is defined
// Parameters: DEPTH (FIFO entries, power of two >= 2), POLL_GAP (idle cycles
// between background polls, 0 = back-to-back).
module uart_rx_fifo_bridge
    import uart_pkg::*;
#(
    parameter int DEPTH    = 2048,
    parameter int POLL_GAP = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    uart_rx_fifo_bridge_if.slave  mmu_axi,
    uart_rx_fifo_bridge_if.master uart_axi,
    output uart_state_e           dbg_state_o
`ifdef UART_RXBUF_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] rx_level_o,
    output logic [$clog2(DEPTH):0] rx_hwm_o
`endif
);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int PCW = $clog2(POLL_GAP + 2);

    uart_state_e    state_q, state_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;

    logic           mmu_arready_q, mmu_arready_d;
    logic           mmu_rvalid_q, mmu_rvalid_d;
    logic [31:0]    mmu_rdata_q, mmu_rdata_d;
    logic [1:0]     mmu_rresp_q, mmu_rresp_d;
    logic           uart_arvalid_q, uart_arvalid_d;
    logic           uart_rready_q, uart_rready_d;
    logic [3:0]     uart_araddr_q, uart_araddr_d;
    logic [2:0]     uart_arprot_q, uart_arprot_d;

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [LW-1:0]  fifo_level;
    logic           mmu_ar_hs;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .wdata_i (uart_axi.rdata[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // arready is high only in IDLE, so an accepted MMU request always starts here.
    assign mmu_ar_hs = (state_q == IDLE) && mmu_arready_q && mmu_axi.arvalid;
    assign fifo_pop  = mmu_ar_hs && (mmu_axi.araddr == UART_RX) && !fifo_empty;
    assign fifo_push = (state_q == POLL_RX_R) && uart_axi.rvalid && uart_rready_q
                       && (uart_axi.rresp == RESP_OKAY);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            poll_cnt_q     <= '0;
            mmu_arready_q  <= 1'b0;
            mmu_rvalid_q   <= 1'b0;
            mmu_rdata_q    <= '0;
            mmu_rresp_q    <= RESP_OKAY;
            uart_arvalid_q <= 1'b0;
            uart_rready_q  <= 1'b0;
            uart_araddr_q  <= '0;
            uart_arprot_q  <= '0;
        end else begin
            state_q        <= state_d;
            poll_cnt_q     <= poll_cnt_d;
            mmu_arready_q  <= mmu_arready_d;
            mmu_rvalid_q   <= mmu_rvalid_d;
            mmu_rdata_q    <= mmu_rdata_d;
            mmu_rresp_q    <= mmu_rresp_d;
            uart_arvalid_q <= uart_arvalid_d;
            uart_rready_q  <= uart_rready_d;
            uart_araddr_q  <= uart_araddr_d;
            uart_arprot_q  <= uart_arprot_d;
        end
    end

    // Next state and poll counter.
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mmu_axi.arvalid) begin
                    // MMU wins over polling; counter holds while a request waits.
                    if (mmu_arready_q)
                        state_d = fifo_pop ? MMU_RESP : FWD_AR;
                end else if (poll_cnt_q == PCW'(POLL_GAP)) begin
                    // A full FIFO parks here; bytes stay queued in the UART.
                    if (!fifo_full) state_d = POLL_STAT_AR;
                end else begin
                    poll_cnt_d = poll_cnt_q + PCW'(1);
                end
            end
            FWD_AR:       if (uart_axi.arready) state_d = FWD_R;
            FWD_R:        if (uart_axi.rvalid)  state_d = MMU_RESP;
            MMU_RESP:     if (mmu_axi.rready)   state_d = IDLE;
            POLL_STAT_AR: if (uart_axi.arready) state_d = POLL_STAT_R;
            POLL_STAT_R: begin
                if (uart_axi.rvalid)
                    state_d = (uart_axi.rresp == RESP_OKAY && uart_axi.rdata[0])
                              ? POLL_RX_AR : IDLE;
            end
            POLL_RX_AR:   if (uart_axi.arready) state_d = POLL_RX_R;
            POLL_RX_R:    if (uart_axi.rvalid)  state_d = IDLE;
            default:      state_d = IDLE;
        endcase
        if (state_d != IDLE) poll_cnt_d = '0;
    end

    // Output register next values, derived from the upcoming state.
    always_comb begin
        mmu_arready_d  = (state_d == IDLE);
        mmu_rvalid_d   = (state_d == MMU_RESP);
        uart_arvalid_d = (state_d == FWD_AR) || (state_d == POLL_STAT_AR) || (state_d == POLL_RX_AR);
        uart_rready_d  = (state_d == FWD_R) || (state_d == POLL_STAT_R) || (state_d == POLL_RX_R);
        uart_araddr_d  = uart_araddr_q;
        uart_arprot_d  = uart_arprot_q;
        mmu_rdata_d    = mmu_rdata_q;
        mmu_rresp_d    = mmu_rresp_q;

        if (state_q == IDLE && state_d == FWD_AR) begin
            uart_araddr_d = mmu_axi.araddr;
            uart_arprot_d = mmu_axi.arprot;
        end
        if (state_q == IDLE && state_d == POLL_STAT_AR) begin
            uart_araddr_d = UART_STAT;
            uart_arprot_d = '0;
        end
        if (state_q == POLL_STAT_R && state_d == POLL_RX_AR)
            uart_araddr_d = UART_RX;

        if (fifo_pop) begin
            mmu_rdata_d = {24'b0, fifo_rdata};
            mmu_rresp_d = RESP_OKAY;
        end
        if (state_q == FWD_R && uart_axi.rvalid) begin
            mmu_rdata_d = uart_axi.rdata;
            // Bytes already drained locally still count as "RX data available".
            if (uart_araddr_q == UART_STAT)
                mmu_rdata_d[0] = uart_axi.rdata[0] | (|fifo_level);
            mmu_rresp_d = uart_axi.rresp;
        end
    end

    assign mmu_axi.arready  = mmu_arready_q;
    assign mmu_axi.rvalid   = mmu_rvalid_q;
    assign mmu_axi.rdata    = mmu_rdata_q;
    assign mmu_axi.rresp    = mmu_rresp_q;
    assign uart_axi.arvalid = uart_arvalid_q;
    assign uart_axi.araddr  = uart_araddr_q;
    assign uart_axi.arprot  = uart_arprot_q;
    assign uart_axi.rready  = uart_rready_q;

    // Write channels: wires only.
    assign uart_axi.awaddr  = mmu_axi.awaddr;
    assign uart_axi.awprot  = mmu_axi.awprot;
    assign uart_axi.awvalid = mmu_axi.awvalid;
    assign mmu_axi.awready  = uart_axi.awready;
    assign uart_axi.wdata   = mmu_axi.wdata;
    assign uart_axi.wstrb   = mmu_axi.wstrb;
    assign uart_axi.wvalid  = mmu_axi.wvalid;
    assign mmu_axi.wready   = uart_axi.wready;
    assign mmu_axi.bresp    = uart_axi.bresp;
    assign mmu_axi.bvalid   = uart_axi.bvalid;
    assign uart_axi.bready  = mmu_axi.bready;

    assign dbg_state_o = state_q;

`ifdef UART_RXBUF_STATS_EN
    logic [LW-1:0] rx_hwm_q;

    always_ff @(posedge clk) begin
        if (!rstn)                    rx_hwm_q <= '0;
        else if (fifo_level > rx_hwm_q) rx_hwm_q <= fifo_level;
    end

    assign rx_level_o = fifo_level;
    assign rx_hwm_o   = rx_hwm_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_bridge.sv
module tb_uart_rx_fifo_bridge;
    import uart_pkg::*;

    localparam int DEPTH    = 4;
    localparam int POLL_GAP = 2;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    uart_rx_fifo_bridge_if mmu_if();
    uart_rx_fifo_bridge_if uart_if();
    uart_state_e dbg_state;
`ifdef UART_RXBUF_STATS_EN
    logic [$clog2(DEPTH):0] rx_level, rx_hwm;
`endif

    uart_rx_fifo_bridge #(.DEPTH(DEPTH), .POLL_GAP(POLL_GAP)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mmu_axi     (mmu_if),
        .uart_axi    (uart_if),
        .dbg_state_o (dbg_state)
`ifdef UART_RXBUF_STATS_EN
        ,
        .rx_level_o  (rx_level),
        .rx_hwm_o    (rx_hwm)
`endif
    );

    // ---------------- counters / reference model state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [33:0] exp_q[$];      // {rresp, rdata} expected per MMU response
    logic [7:0]  pending_q[$];  // bytes received by the system, not yet read by the MMU
    logic [7:0]  uart_q[$];     // bytes still inside the UART model

    logic [31:0] stat_extra = 32'h0;
    logic [31:0] tx_reg     = 32'h0;
    logic [31:0] ctrl_reg   = 32'h0;
    logic [1:0]  ctrl_resp  = 2'b00;
    int r_dmin = 0;
    int r_dmax = 3;

    int rsp_cnt     = 0;
    int rv_rise_cyc = 0;
    int ar_rx_cnt   = 0;
    int last_r_cyc  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // System-level view: RX reads return bytes in arrival order, nothing lost;
    // STAT bit0 reports whether any received byte is still unread.
    task automatic model_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
        r = RESP_OKAY;
        d = 32'h0;
        case (a)
            UART_RX:   if (pending_q.size() != 0) d = {24'h0, pending_q.pop_front()};
            UART_STAT: d = stat_extra | {31'h0, pending_q.size() != 0};
            UART_TX:   d = tx_reg;
            UART_CTRL: begin d = ctrl_reg; r = ctrl_resp; end
            default:   ;
        endcase
    endtask

    task automatic inject_byte(input logic [7:0] b);
        uart_q.push_back(b);
        pending_q.push_back(b);
    endtask

    task automatic inject(input int n);
        for (int i = 0; i < n; i++) inject_byte(8'($urandom_range(0, 255)));
    endtask

    // ---------------- UART responder ----------------
    initial begin
        logic [3:0] a;
        uart_if.arready = 1'b0;
        uart_if.rvalid  = 1'b0;
        uart_if.rdata   = 32'h0;
        uart_if.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (rstn && uart_if.arvalid === 1'b1) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                uart_if.arready = 1'b1;
                a = uart_if.araddr;
                @(negedge clk);
                uart_if.arready = 1'b0;
                if (a == UART_RX) ar_rx_cnt++;
                repeat ($urandom_range(r_dmin, r_dmax)) @(negedge clk);
                uart_if.rresp = RESP_OKAY;
                case (a)
                    UART_RX:   uart_if.rdata = (uart_q.size() != 0) ? {24'h0, uart_q.pop_front()} : 32'h0;
                    UART_STAT: uart_if.rdata = stat_extra | {31'h0, uart_q.size() != 0};
                    UART_TX:   uart_if.rdata = tx_reg;
                    UART_CTRL: begin uart_if.rdata = ctrl_reg; uart_if.rresp = ctrl_resp; end
                    default:   uart_if.rdata = 32'h0;
                endcase
                uart_if.rvalid = 1'b1;
                last_r_cyc = cyc;
                @(negedge clk);
                uart_if.rvalid = 1'b0;
            end
        end
    end

    // ---------------- MMU rready driver ----------------
    initial begin
        mmu_if.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1 mmu_if.rready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [33:0] e;
        logic prev_rv;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (mmu_if.rvalid === 1'b1 && !prev_rv) rv_rise_cyc = cyc;
            prev_rv = (mmu_if.rvalid === 1'b1);
            if (rstn && mmu_if.rvalid === 1'b1 && mmu_if.rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 64'(mmu_if.rdata), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("mmu_rdata", 64'(mmu_if.rdata), 64'(e[31:0]));
                    check("mmu_rresp", 64'(mmu_if.rresp), 64'(e[33:32]));
                end
                rsp_cnt++;
            end
        end
    end

    // ---------------- MMU driver ----------------
    task automatic mmu_read(input logic [3:0] addr, output int hs_cyc);
        logic [31:0] d;
        logic [1:0]  r;
        int budget;
        int target;
        model_read(addr, d, r);
        exp_q.push_back({r, d});
        target = rsp_cnt + 1;
        @(negedge clk);
        mmu_if.araddr  = addr;
        mmu_if.arprot  = 3'($urandom_range(0, 7));
        mmu_if.arvalid = 1'b1;
        budget = 0;
        while (mmu_if.arready !== 1'b1 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        hs_cyc = cyc;
        if (budget >= 300) begin
            fail_now("mmu_arready");
            void'(exp_q.pop_back());
            mmu_if.arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        mmu_if.arvalid = 1'b0;
        budget = 0;
        while (rsp_cnt < target && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) fail_now("mmu_rvalid");
    endtask

    task automatic drain_all();
        int hs;
        while (pending_q.size() != 0) mmu_read(UART_RX, hs);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hs;
        int ar0;
        int rises;
        int budget;
        logic prev_av;
        logic [3:0] a4;

        mmu_if.araddr  = 4'h0;
        mmu_if.arprot  = 3'h0;
        mmu_if.arvalid = 1'b0;
        mmu_if.awaddr  = 4'h0;
        mmu_if.awprot  = 3'h0;
        mmu_if.awvalid = 1'b0;
        mmu_if.wdata   = 32'h0;
        mmu_if.wstrb   = 4'h0;
        mmu_if.wvalid  = 1'b0;
        mmu_if.bready  = 1'b0;
        uart_if.awready = 1'b0;
        uart_if.wready  = 1'b0;
        uart_if.bresp   = 2'b00;
        uart_if.bvalid  = 1'b0;

        // Reset values.
        repeat (4) @(negedge clk);
        check("rst_mmu_ar_r", {mmu_if.arready, mmu_if.rvalid, mmu_if.rresp, mmu_if.rdata}, 64'h0);
        check("rst_uart_ar_r", {uart_if.arvalid, uart_if.rready, uart_if.araddr, uart_if.arprot}, 64'h0);
        rstn = 1'b1;

        // Idle polling with STAT bit0=0: only 0x8 polls, spaced by >= POLL_GAP+1 idle cycles.
        rises   = 0;
        prev_av = 1'b0;
        ar0     = ar_rx_cnt;
        last_r_cyc = -1;
        repeat (80) begin
            @(negedge clk);
            if (uart_if.arvalid && !prev_av) begin
                rises++;
                check("poll_addr", 64'(uart_if.araddr), 64'(UART_STAT));
                if (last_r_cyc >= 0)
                    check("poll_gap_ok", 64'((cyc - last_r_cyc) >= POLL_GAP + 2), 64'h1);
            end
            prev_av = uart_if.arvalid;
        end
        check("poll_seen", 64'(rises >= 3), 64'h1);
        check("poll_no_rx", 64'(ar_rx_cnt - ar0), 64'h0);

        // Write channel pass-through (combinational).
        repeat (4) begin
            logic [46:0] mw;
            logic [4:0]  ub;
            @(negedge clk);
            mw = {4'($urandom), 3'($urandom), 1'($urandom), 32'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)};
            ub = 5'($urandom);
            {mmu_if.awaddr, mmu_if.awprot, mmu_if.awvalid, mmu_if.wdata, mmu_if.wstrb,
             mmu_if.wvalid, mmu_if.bready} = mw[46:1];
            {uart_if.awready, uart_if.wready, uart_if.bresp, uart_if.bvalid} = ub;
            #1;
            check("wr_fwd", 64'({uart_if.awaddr, uart_if.awprot, uart_if.awvalid, uart_if.wdata,
                                 uart_if.wstrb, uart_if.wvalid, uart_if.bready}), 64'(mw[46:1]));
            check("wr_back", 64'({mmu_if.awready, mmu_if.wready, mmu_if.bresp, mmu_if.bvalid}), 64'(ub));
        end

        // Two bytes drained by polling, then served from the FIFO.
        inject_byte(8'h41);
        inject_byte(8'h42);
        repeat (120) @(negedge clk);
        check("drain_two", 64'(uart_q.size()), 64'h0);
        repeat (2) begin
            ar0 = ar_rx_cnt;
            mmu_read(UART_RX, hs);
            check("hit_latency", 64'(rv_rise_cyc - hs), 64'h1);
            check("hit_no_uart_ar", 64'(ar_rx_cnt - ar0), 64'h0);
        end

        // Empty FIFO: RX read is forwarded; UART returns 0x00.
        ar0 = ar_rx_cnt;
        mmu_read(UART_RX, hs);
        check("fwd_rx_uart_ar", 64'(ar_rx_cnt - ar0), 64'h1);

        // One byte buffered, UART STAT = 0x04: MMU sees 0x05.
        inject(1);
        repeat (80) @(negedge clk);
        stat_extra = 32'h0000_0004;
        mmu_read(UART_STAT, hs);
        drain_all();
        mmu_read(UART_STAT, hs);
        stat_extra = 32'h0;

        // Six bytes into DEPTH=4: polling stops at full, resumes after one pop.
        inject(6);
        repeat (250) @(negedge clk);
        check("full_left_in_uart", 64'(uart_q.size()), 64'(6 - DEPTH));
        mmu_read(UART_RX, hs);
        repeat (120) @(negedge clk);
        check("resume_after_pop", 64'(uart_q.size()), 64'(6 - DEPTH - 1));
        drain_all();

        // MMU request raised while a RX poll is waiting for its data.
        r_dmin = 3;
        r_dmax = 4;
        inject(1);
        budget = 0;
        @(negedge clk);
        while (!(uart_if.rready && uart_if.araddr == UART_RX) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) fail_now("poll_rx_r");
        check("arready_low_in_poll", 64'(mmu_if.arready), 64'h0);
        mmu_read(UART_RX, hs);
        r_dmin = 0;
        r_dmax = 3;

        // Reset with buffered bytes discards them.
        inject(2);
        repeat (120) @(negedge clk);
        check("pre_reset_drained", 64'(uart_q.size()), 64'h0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_valids", 64'({mmu_if.rvalid, mmu_if.arready, uart_if.arvalid, uart_if.rready}), 64'h0);
        repeat (8) @(negedge clk);
        pending_q.delete();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        mmu_read(UART_RX, hs);
        mmu_read(UART_STAT, hs);

        // Randomised mix.
        tx_reg    = $urandom;
        ctrl_reg  = $urandom;
        ctrl_resp = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        stat_extra = $urandom & 32'hFFFF_FFFE;
        repeat (60) begin
            case ($urandom_range(0, 5))
                0: if (pending_q.size() < 10) inject($urandom_range(1, 3));
                1: repeat ($urandom_range(5, 40)) @(negedge clk);
                2: begin
                    a4 = 4'($urandom_range(0, 3) << 2);
                    mmu_read(a4, hs);
                end
                default: mmu_read(UART_RX, hs);
            endcase
        end
        drain_all();
        mmu_read(UART_RX, hs);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end
endmodule
